// File: rtl/pulse_window_ctrl.sv
// rtl/pulse_window_ctrl.sv - pulse filter, timed BCD counting window and result latch
// Raw Pulse is synchronised and run-length filtered; qualified edges are counted in BCD per window.
module pulse_window_ctrl #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int FILTER_LEN    = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Pulse,
  input  logic       Start,
  input  logic       Continuous,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Tens,
  output logic [3:0] Units,
  output logic       Overflow
);

  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [TW-1:0] TIMER_INIT = TW'(WINDOW_CYCLES - 1);
  localparam logic [FW-1:0] RUN_LAST   = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_COUNT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            sync_q1;
  logic            sync_q2;
  logic            filt_level;
  logic [FW-1:0]   run_cnt;
  logic            pulse_event;
  logic [TW-1:0]   timer;
  logic [3:0]      work_tens;
  logic [3:0]      work_units;
  logic            work_ovf;
  logic [3:0]      next_tens;
  logic [3:0]      next_units;
  logic            next_ovf;
  logic            enter_latch;

  // run_cnt counts consecutive synchronised samples that disagree with the filtered level
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      filt_level  <= 1'b0;
      run_cnt     <= '0;
      pulse_event <= 1'b0;
    end else begin
      sync_q1     <= Pulse;
      sync_q2     <= sync_q1;
      pulse_event <= 1'b0;
      if (sync_q2 == filt_level) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        filt_level  <= sync_q2;
        run_cnt     <= '0;
        pulse_event <= sync_q2;
      end else begin
        run_cnt <= run_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start) state_next = S_CLEAR;
      S_CLEAR: state_next = S_COUNT;
      S_COUNT: if (timer == '0) state_next = S_LATCH;
      S_LATCH: state_next = Continuous ? S_CLEAR : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != S_IDLE);
    Done = (state == S_LATCH);
  end

  // The latched result uses the post-increment values so an event in the last COUNT cycle is kept
  always_comb begin
    next_tens  = work_tens;
    next_units = work_units;
    next_ovf   = work_ovf;
    if ((state == S_COUNT) && pulse_event) begin
      if ((work_tens == 4'd9) && (work_units == 4'd9)) begin
        next_ovf = 1'b1;
      end else if (work_units == 4'd9) begin
        next_units = 4'd0;
        next_tens  = work_tens + 4'd1;
      end else begin
        next_units = work_units + 4'd1;
      end
    end
  end

  assign enter_latch = (state == S_COUNT) && (timer == '0);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      timer      <= '0;
      work_tens  <= 4'd0;
      work_units <= 4'd0;
      work_ovf   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          timer      <= TIMER_INIT;
          work_tens  <= 4'd0;
          work_units <= 4'd0;
          work_ovf   <= 1'b0;
        end
        S_COUNT: begin
          if (timer != '0) timer <= timer - TW'(1);
          work_tens  <= next_tens;
          work_units <= next_units;
          work_ovf   <= next_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Tens     <= 4'd0;
      Units    <= 4'd0;
      Overflow <= 1'b0;
    end else if (enter_latch) begin
      Tens     <= next_tens;
      Units    <= next_units;
      Overflow <= next_ovf;
    end
  end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// tb/tb_pulse_window_ctrl.sv - self-checking bench for pulse_window_ctrl
module tb_pulse_window_ctrl;

  localparam int WA = 200;
  localparam int WB = 3000;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pa = 1'b0, sa = 1'b0, ca = 1'b0;
  logic pb = 1'b0, sb = 1'b0, cb = 1'b0;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [3:0] tens_a, units_a, tens_b, units_b;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_window_ctrl #(.WINDOW_CYCLES(WA), .FILTER_LEN(FL)) dut_a (
    .CLK(clk), .Reset(rst), .Pulse(pa), .Start(sa), .Continuous(ca),
    .Busy(busy_a), .Done(done_a), .Tens(tens_a), .Units(units_a), .Overflow(ovf_a));

  pulse_window_ctrl #(.WINDOW_CYCLES(WB), .FILTER_LEN(FL)) dut_b (
    .CLK(clk), .Reset(rst), .Pulse(pb), .Start(sb), .Continuous(cb),
    .Busy(busy_b), .Done(done_b), .Tens(tens_b), .Units(units_b), .Overflow(ovf_b));

  // Reference: pulses-per-window, saturated at 99, split into decimal digits
  function automatic logic [8:0] ref_result(input int n);
    int sat;
    sat = (n > 99) ? 99 : n;
    return {4'(sat / 10), 4'(sat % 10), (n > 99)};
  endfunction

  function automatic logic [8:0] got(input bit sel);
    return sel ? {tens_b, units_b, ovf_b} : {tens_a, units_a, ovf_a};
  endfunction

  task automatic pulse(input bit sel, input int hi, input int lo);
    if (sel) pb = 1'b1; else pa = 1'b1;
    repeat (hi) @(negedge clk);
    if (sel) pb = 1'b0; else pa = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic start_meas(input bit sel, output int s);
    if (sel) sb = 1'b1; else sa = 1'b1;
    @(negedge clk);
    if (sel) sb = 1'b0; else sa = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input bit sel, input int s, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? done_b : done_a) === 1'b1) begin
        at = cyc - s + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, tens_a, units_a, ovf_a} !== 11'd0) begin
      n_err++; $display("FAIL reset_a: got %b required 0", {busy_a, done_a, tens_a, units_a, ovf_a});
    end
    n_cmp++;
    if ({busy_b, done_b, tens_b, units_b, ovf_b} !== 11'd0) begin
      n_err++; $display("FAIL reset_b: got %b required 0", {busy_b, done_b, tens_b, units_b, ovf_b});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean7();
    int s, at;
    start_meas(0, s);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_err++; $display("FAIL clean7_busy: got %b required 1", busy_a); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) pulse(0, 8, 8);
    wait_done(0, s, 400, at);
    n_cmp++;
    if (at !== WA + 2) begin n_err++; $display("FAIL clean7_latency: got %0d required %0d", at, WA + 2); end
    n_cmp++;
    if (got(0) !== ref_result(7)) begin n_err++; $display("FAIL clean7_result: got %h required %h", got(0), ref_result(7)); end
    @(negedge clk);
    n_cmp++;
    if ({done_a, busy_a} !== 2'b00) begin n_err++; $display("FAIL clean7_after: done/busy got %b required 00", {done_a, busy_a}); end
  endtask

  task automatic test_glitch();
    int s, at;
    start_meas(0, s);
    for (int i = 0; i < 10; i++) pulse(0, $urandom_range(1, FL - 1), FL);
    for (int i = 0; i < 12; i++) begin
      pulse(0, 5, FL);
      if (i == 9) begin
        n_cmp++;
        if ({dut_a.work_tens, dut_a.work_units} !== 8'h10) begin
          n_err++; $display("FAIL glitch_carry: got %h required 10", {dut_a.work_tens, dut_a.work_units});
        end
      end
    end
    wait_done(0, s, 400, at);
    n_cmp++;
    if (at !== WA + 2) begin n_err++; $display("FAIL glitch_latency: got %0d required %0d", at, WA + 2); end
    n_cmp++;
    if (got(0) !== ref_result(12)) begin n_err++; $display("FAIL glitch_result: got %h required %h", got(0), ref_result(12)); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int s, at;
    start_meas(1, s);
    for (int i = 0; i < 120; i++) pulse(1, 6, 6);
    wait_done(1, s, 4000, at);
    n_cmp++;
    if (at !== WB + 2) begin n_err++; $display("FAIL ovf_latency: got %0d required %0d", at, WB + 2); end
    n_cmp++;
    if (got(1) !== ref_result(120)) begin n_err++; $display("FAIL ovf_result: got %h required %h", got(1), ref_result(120)); end
    repeat (2) @(negedge clk);
    start_meas(1, s);
    for (int i = 0; i < 4; i++) pulse(1, 6, 6);
    wait_done(1, s, 4000, at);
    n_cmp++;
    if (got(1) !== ref_result(4)) begin n_err++; $display("FAIL ovf_next: got %h required %h", got(1), ref_result(4)); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int s, at, n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(0, 9);
      start_meas(0, s);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) pulse(0, $urandom_range(1, FL - 1), FL);
        pulse(0, $urandom_range(FL, FL + 2), $urandom_range(FL, FL + 2));
      end
      wait_done(0, s, 400, at);
      n_cmp++;
      if (at !== WA + 2) begin n_err++; $display("FAIL random_latency[%0d]: got %0d required %0d", it, at, WA + 2); end
      n_cmp++;
      if (got(0) !== ref_result(n)) begin
        n_err++; $display("FAIL random_result[%0d]: got %h required %h (n=%0d)", it, got(0), ref_result(n), n);
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    int s, at;
    ca = 1'b1;
    start_meas(0, s);
    for (int i = 0; i < 3; i++) pulse(0, 8, 8);
    sa = 1'b1; @(negedge clk); sa = 1'b0;
    wait_done(0, s, 400, at);
    n_cmp++;
    if (at !== WA + 2) begin n_err++; $display("FAIL cont_latency1: got %0d required %0d", at, WA + 2); end
    n_cmp++;
    if (got(0) !== ref_result(3)) begin n_err++; $display("FAIL cont_result1: got %h required %h", got(0), ref_result(3)); end
    @(negedge clk);
    n_cmp++;
    if ({done_a, busy_a} !== 2'b01) begin n_err++; $display("FAIL cont_rearm: done/busy got %b required 01", {done_a, busy_a}); end
    for (int i = 0; i < 5; i++) begin
      pulse(0, 8, 8);
      if (i == 1) begin
        ca = 1'b0;
        sa = 1'b1; @(negedge clk); sa = 1'b0;
      end
    end
    wait_done(0, s, 400, at);
    n_cmp++;
    if (at !== 2 * (WA + 2)) begin n_err++; $display("FAIL cont_latency2: got %0d required %0d", at, 2 * (WA + 2)); end
    n_cmp++;
    if (got(0) !== ref_result(5)) begin n_err++; $display("FAIL cont_result2: got %h required %h", got(0), ref_result(5)); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL cont_idle: busy got %b required 0", busy_a); end
  endtask

  task automatic test_midreset();
    int s, at;
    start_meas(0, s);
    for (int i = 0; i < 6; i++) pulse(0, 8, 8);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %b required 1", busy_a); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_a, done_a, tens_a, units_a, ovf_a} !== 11'd0) begin
      n_err++; $display("FAIL midrst_async: got %b required 0", {busy_a, done_a, tens_a, units_a, ovf_a});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_meas(0, s);
    for (int i = 0; i < 2; i++) pulse(0, 8, 8);
    wait_done(0, s, 400, at);
    n_cmp++;
    if (at !== WA + 2) begin n_err++; $display("FAIL midrst_latency: got %0d required %0d", at, WA + 2); end
    n_cmp++;
    if (got(0) !== ref_result(2)) begin n_err++; $display("FAIL midrst_result: got %h required %h", got(0), ref_result(2)); end
  endtask

  initial begin
    test_reset();
    test_clean7();
    test_glitch();
    test_overflow();
    test_random();
    test_continuous();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pulse_window_ctrl.md
Name: pulse_window_ctrl

Overview:
Measurement controller for the pulse-counting path. It synchronises and filters the raw Pulse input, then opens a timed counting window. During the window it counts qualified rising edges in BCD, saturating at 99. At window close it latches the result into the Tens/Units display registers. It runs single-shot on Start or back-to-back in Continuous mode, so the display shows pulses-per-window rather than a free-running total.

Parameters:
WINDOW_CYCLES, 1000, length of the counting window in CLK cycles (>=2)
FILTER_LEN, 4, number of consecutive equal synchronised samples needed to change the filtered level (>=2)

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Pulse  input  1  raw, asynchronous pulse input
Start  input  1  request one measurement; sampled only in IDLE
Continuous  input  1  when 1, LATCH returns to CLEAR instead of IDLE
Busy  output  1  high in CLEAR, COUNT and LATCH
Done  output  1  high for exactly one cycle, in LATCH
Tens  output  4  latched BCD tens digit, 0-9
Units  output  4  latched BCD units digit, 0-9
Overflow  output  1  latched; 1 if the window saw more than 99 events

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high. All flops clear on Reset: state=IDLE; Busy, Done, Tens, Units, Overflow, filter and sync registers, working counters all 0.
- Input conditioning:
  - Pulse passes through a 2-flop synchroniser.
  - Filtered level rises after FILTER_LEN consecutive high synchronised samples and falls after FILTER_LEN consecutive lows. Shorter runs are ignored.
  - event = one-cycle strobe on the filtered level's 0->1 transition.
  - Fixed latency from raw Pulse rise to event is FILTER_LEN+2 cycles.
- FSM states: IDLE, CLEAR, COUNT, LATCH.
  - IDLE: Start=1 -> CLEAR. Otherwise stay.
  - CLEAR (1 cycle): working BCD digits <= 0, working overflow <= 0, window timer <= WINDOW_CYCLES-1. Next state COUNT.
  - COUNT: timer decrements each cycle. When timer==0 -> LATCH, so COUNT lasts exactly WINDOW_CYCLES cycles.
  - LATCH (1 cycle): Done=1. Next state CLEAR if Continuous=1, else IDLE. Continuous is sampled in LATCH only.
- Counting:
  - An event in a COUNT cycle, including the last one, increments the working count.
  - Events in IDLE, CLEAR or LATCH are dropped.
  - BCD increment: units 9 -> 0 with tens +1.
  - At 99, a further event holds 99 and sets working overflow, which stays set until CLEAR.
- Latch timing:
  - On the edge entering LATCH, Tens/Units/Overflow <= working values.
  - Outputs are therefore valid in the same cycle Done=1 and hold until the next LATCH or Reset.
- Handshake and latency:
  - Start sampled at edge k gives CLEAR in cycle k+1, COUNT in cycles k+2 .. k+1+WINDOW_CYCLES, and LATCH/Done in cycle k+2+WINDOW_CYCLES.
  - In Continuous mode, Done repeats every WINDOW_CYCLES+2 cycles.
  - Start while Busy=1 is ignored; no queuing.
  - Clearing Continuous mid-window completes the current window, then returns to IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The partial count is discarded.

Test Plan:
1. Assert Reset in mid-simulation -> Busy=0, Done=0, Tens=0, Units=0, Overflow=0 asynchronously, before the next CLK edge.
2. WINDOW_CYCLES=200, FILTER_LEN=4. Start, then 7 clean pulses (8 high / 8 low) well inside the window -> Done high exactly one cycle at Start+202, Tens=0, Units=7, Overflow=0; Busy falls the following cycle.
3. Same window: 10 glitches of 3 cycles high plus 12 pulses of 5 cycles high -> Tens=1, Units=2. Also check units carry 9->0 at the 10th pulse.
4. WINDOW_CYCLES=3000: 120 clean pulses (6 high / 6 low) -> Tens=9, Units=9, Overflow=1. The next window with 4 pulses -> Tens=0, Units=4, Overflow=0.
5. Continuous=1, WINDOW_CYCLES=200: 3 pulses in window 1, then 5 in window 2 -> Done at Start+202 with 0/3, and at Start+404 with 0/5. Start pulses while Busy have no effect. Dropping Continuous in window 2 leaves IDLE after the second Done.
6. Reset asserted mid-COUNT after 6 pulses, released, then Start with 2 pulses -> outputs 0 during reset; final result Tens=0, Units=2 (no carry-over from the aborted window).
